// File: rtl/timer_control.sv
// Kitchen-timer sequencer: remaining-time register, 1 Hz prescaler and IDLE/RUN/PAUSE/ALARM control.
// Optional macro ALARM_TIMEOUT_EN makes ALARM clear itself after ALARM_TICKS prescaler wraps.
module timer_control #(
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_COUNT   = 3599,
    parameter int ALARM_TICKS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [11:0] count_next,
    output logic [11:0] count_value,
    output logic        count_up,
    output logic [11:0] max_count,
    output logic        tick,
    output logic        running,
    output logic        alarm
);

    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic          presc_wrap;
    logic [PW-1:0] presc_adv;
    logic          alarm_expire;

    assign presc_wrap = (presc == PW'(TICK_DIV - 1));
    assign presc_adv  = presc_wrap ? '0 : presc + 1'b1;

    assign max_count  = 12'(MAX_COUNT);
    assign count_up   = (state == IDLE) && btn_inc && !btn_dec;
    assign tick       = (state == RUN) && presc_wrap;
    assign running    = (state == RUN);
    assign alarm      = (state == ALARM);

`ifdef ALARM_TIMEOUT_EN
    localparam int AW = $clog2(ALARM_TICKS + 1);

    logic [AW-1:0] alarm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_cnt <= '0;
        end else if (state != ALARM) begin
            alarm_cnt <= '0;
        end else if (presc_wrap) begin
            alarm_cnt <= alarm_cnt + 1'b1;
        end
    end

    assign alarm_expire = (state == ALARM) && presc_wrap && (alarm_cnt == AW'(ALARM_TICKS - 1));
`else
    assign alarm_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count_value <= '0;
            presc       <= '0;
        end else if (btn_clear) begin
            state       <= IDLE;
            count_value <= '0;
            presc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Start outranks inc/dec even when it is ignored at zero.
                    if (btn_start) begin
                        if (count_value != '0) begin
                            state <= RUN;
                            presc <= '0;
                        end
                    end else if (btn_inc && !btn_dec) begin
                        count_value <= count_next;
                    end else if (btn_dec && !btn_inc && count_value != '0) begin
                        count_value <= count_next;
                    end
                end
                RUN: begin
                    // Pausing freezes the prescaler and drops a coincident tick.
                    if (btn_start) begin
                        state <= PAUSE;
                    end else begin
                        presc <= presc_adv;
                        if (presc_wrap) begin
                            count_value <= count_next;
                            if (count_value == 12'd1) begin
                                state <= ALARM;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (btn_start) begin
                        state <= RUN;
                    end
                end
                ALARM: begin
                    if (btn_start || alarm_expire) begin
                        state <= IDLE;
                        presc <= '0;
                    end else begin
                        presc <= presc_adv;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control with TICK_DIV=4; models the combinational up/down counter stage.
// Define ALARM_TIMEOUT_EN on both files to exercise the alarm auto-clear path.
module tb_timer_control;

    localparam int TICK_DIV    = 4;
    localparam int MAX_COUNT   = 3599;
    localparam int ALARM_TICKS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [11:0] count_next;
    logic [11:0] count_value;
    logic        count_up;
    logic [11:0] max_count;
    logic        tick;
    logic        running;
    logic        alarm;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {count_value, running, alarm} for table vectors.
    logic [13:0] exp_q[$];

    typedef struct {
        string       name;
        logic        start;
        logic        clear;
        logic        inc;
        logic        dec;
        logic        exp_up;
        logic [11:0] exp_value;
        logic        exp_running;
        logic        exp_alarm;
    } vec_t;

    vec_t vecs[12];

    timer_control #(
        .TICK_DIV   (TICK_DIV),
        .MAX_COUNT  (MAX_COUNT),
        .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .count_next (count_next),
        .count_value(count_value),
        .count_up   (count_up),
        .max_count  (max_count),
        .tick       (tick),
        .running    (running),
        .alarm      (alarm)
    );

    always #5 clk = ~clk;

    // Downstream counter stage: wraps MAX_COUNT -> 0 upward, plain 12-bit decrement downward.
    always_comb begin
        count_next = 12'd0;
        if (count_up) begin
            count_next = (count_value == 12'(MAX_COUNT)) ? 12'd0 : count_value + 12'd1;
        end else begin
            count_next = count_value - 12'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one-cycle button pulse from a falling edge; returns on the next falling edge.
    task automatic pulse(input logic s, input logic c, input logic i, input logic d);
        btn_start = s;
        btn_clear = c;
        btn_inc   = i;
        btn_dec   = d;
        @(negedge clk);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_inc   = 1'b0;
        btn_dec   = 1'b0;
    endtask

    initial begin
        logic [13:0] got;
        logic [13:0] want;
        logic [11:0] exp_v;
        logic        exp_tick;

        vecs[0]  = '{"inc_1",       1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0};
        vecs[1]  = '{"inc_2",       1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd2, 1'b0, 1'b0};
        vecs[2]  = '{"inc_3",       1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd3, 1'b0, 1'b0};
        vecs[3]  = '{"dec_2",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd2, 1'b0, 1'b0};
        vecs[4]  = '{"dec_1",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0};
        vecs[5]  = '{"dec_0",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0};
        vecs[6]  = '{"dec_floor",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0};
        vecs[7]  = '{"incdec_at_0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0};
        vecs[8]  = '{"inc_again",   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0};
        vecs[9]  = '{"incdec_at_1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0};
        vecs[10] = '{"clear_idle",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};
        vecs[11] = '{"start_at_0",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};

        // Reset held for 3 cycles
        cycles(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_value", 32'(count_value), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("max_count", 32'(max_count), 32'd3599);

        // Table-driven set mode
        for (int v = 0; v < 12; v++) begin
            btn_start = vecs[v].start;
            btn_clear = vecs[v].clear;
            btn_inc   = vecs[v].inc;
            btn_dec   = vecs[v].dec;
            exp_q.push_back({vecs[v].exp_value, vecs[v].exp_running, vecs[v].exp_alarm});
            #1;
            check({vecs[v].name, "_count_up"}, 32'(count_up), 32'(vecs[v].exp_up));
            @(negedge clk);
            btn_start = 1'b0;
            btn_clear = 1'b0;
            btn_inc   = 1'b0;
            btn_dec   = 1'b0;
            got  = {count_value, running, alarm};
            want = exp_q.pop_front();
            check(vecs[v].name, 32'(got), 32'(want));
        end

        // Set to MAX_COUNT, then one more inc wraps to 0
        for (int i = 0; i < MAX_COUNT; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("set_max", 32'(count_value), 32'(MAX_COUNT));
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("wrap_max", 32'(count_value), 32'd0);

        // Countdown from 3 into ALARM
        repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        exp_v = 12'd3;
        for (int k = 1; k <= 12; k++) begin
            exp_tick = (k % TICK_DIV == 0);
            check("cd_tick", 32'(tick), 32'(exp_tick));
            check("cd_value", 32'(count_value), 32'(exp_v));
            check("cd_running", 32'(running), 32'd1);
            @(negedge clk);
            if (exp_tick) exp_v = exp_v - 12'd1;
        end
        check("cd_end_value", 32'(count_value), 32'd0);
        check("cd_alarm", 32'(alarm), 32'd1);
        check("cd_not_running", 32'(running), 32'd0);

`ifdef ALARM_TIMEOUT_EN
        cycles(7);
        check("alarm_before_timeout", 32'(alarm), 32'd1);
        cycles(1);
        check("alarm_timeout", 32'(alarm), 32'd0);
        check("alarm_timeout_value", 32'(count_value), 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            check("alarm_tick_low", 32'(tick), 32'd0);
        end
        check("alarm_persists", 32'(alarm), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("alarm_start_exit", 32'(alarm), 32'd0);
        check("alarm_exit_running", 32'(running), 32'd0);
`endif

        // Pause and resume from 5
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(3);
        check("pz_first_tick", 32'(tick), 32'd1);
        cycles(3);
        check("pz_value_before", 32'(count_value), 32'd4);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            check("pz_hold_value", 32'(count_value), 32'd4);
            check("pz_hold_tick", 32'(tick), 32'd0);
            check("pz_hold_running", 32'(running), 32'd0);
            @(negedge clk);
        end
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("pz_resume_running", 32'(running), 32'd1);
        check("pz_resume_no_tick", 32'(tick), 32'd0);
        cycles(1);
        check("pz_resume_tick", 32'(tick), 32'd1);
        cycles(1);
        check("pz_resume_value", 32'(count_value), 32'd3);
        cycles(3);
        check("pz_tick_at_pause", 32'(tick), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("pz_tick_discarded", 32'(count_value), 32'd3);
        check("pz_paused_again", 32'(running), 32'd0);

        // Clear beats start in RUN; start at zero is ignored
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(1);
        check("prio_running", 32'(running), 32'd1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_value", 32'(count_value), 32'd0);
        check("prio_running_off", 32'(running), 32'd0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_zero_idle", 32'(running), 32'd0);

        // Asynchronous reset mid-RUN
        repeat (2) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        cycles(2);
        check("mid_run_running", 32'(running), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_value", 32'(count_value), 32'd0);
        check("mid_rst_running", 32'(running), 32'd0);
        check("mid_rst_alarm", 32'(alarm), 32'd0);
        check("mid_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(2);
        check("post_rst_idle", 32'(running), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
